// File: rtl/multi_dev_bridge.sv
// CPU-side bridge that decodes accesses onto data memory, N_DEV device windows and an interrupt byte range.
// Define BRIDGE_ERR_EN to build the sticky bus-error flag and its error registers at 0x7f30..0x7f37.
module multi_dev_bridge #(
    parameter int          N_DEV    = 2,
    parameter logic [31:0] DEV_BASE = 32'h0000_7f00,
    parameter int          WAIT_CYC = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pr_req,
    input  logic                 pr_we,
    input  logic [3:0]           pr_byteen,
    input  logic [31:0]          pr_addr,
    input  logic [31:0]          pr_wd,
    output logic [31:0]          pr_rd,
    output logic                 pr_ready,
    output logic [31:0]          dev_addr,
    output logic [31:0]          dev_wd,
    output logic [N_DEV-1:0]     dev_we,
    input  logic [32*N_DEV-1:0]  dev_rd,
    input  logic [31:0]          dm_rdata,
    output logic                 int_byteen,
    output logic                 err_flag
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] dev_addr_q, dev_addr_d;
    logic [31:0] dev_wd_q, dev_wd_d;
    logic [1:0]  sel_q, sel_d;

    logic             dm_hit, int_hit, err_hit, dev_hit, unmapped;
    logic [N_DEV-1:0] dev_vec;
    logic [1:0]       dev_idx;
    logic [31:0]      win_base;
    logic [31:0]      idx_word, sel_word;

    logic             ready, err_set, err_clr;
    logic [31:0]      rd, wd_out, addr_out;
    logic [N_DEV-1:0] we_vec;

`ifdef BRIDGE_ERR_EN
    logic        err_flag_q, err_flag_d;
    logic [31:0] err_addr_q, err_addr_d;
`endif

    // INT and error registers take priority should a wide N_DEV overlap them.
    always_comb begin
        dm_hit  = (pr_addr <= 32'h0000_2fff);
        int_hit = (pr_addr >= 32'h0000_7f20) && (pr_addr <= 32'h0000_7f23);
`ifdef BRIDGE_ERR_EN
        err_hit = (pr_addr >= 32'h0000_7f30) && (pr_addr <= 32'h0000_7f37);
`else
        err_hit = 1'b0;
`endif
        dev_vec  = '0;
        dev_idx  = '0;
        win_base = DEV_BASE;
        for (int k = 0; k < N_DEV; k++) begin
            win_base = DEV_BASE + 32'(16 * k);
            if (!int_hit && !err_hit && (pr_addr >= win_base) && ((pr_addr - win_base) < 32'd12)) begin
                dev_vec[k] = 1'b1;
                dev_idx    = 2'(k);
            end
        end
        dev_hit  = |dev_vec;
        unmapped = !(dm_hit || int_hit || err_hit || dev_hit);
    end

    always_comb begin
        idx_word = '0;
        sel_word = '0;
        for (int k = 0; k < N_DEV; k++) begin
            if (dev_idx == 2'(k)) idx_word = dev_rd[32*k +: 32];
            if (sel_q == 2'(k))   sel_word = dev_rd[32*k +: 32];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        dev_addr_d = dev_addr_q;
        dev_wd_d   = dev_wd_q;
        sel_d      = sel_q;
        ready      = 1'b0;
        rd         = '0;
        we_vec     = '0;
        wd_out     = dev_wd_q;
        addr_out   = dev_addr_q;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pr_req) begin
                    if (dev_hit && pr_we) begin
                        ready = 1'b1;
                        if (pr_byteen == 4'b1111) begin
                            we_vec     = dev_vec;
                            wd_out     = pr_wd;
                            addr_out   = pr_addr;
                            dev_wd_d   = pr_wd;
                            dev_addr_d = pr_addr;
                        end else begin
                            err_set = 1'b1;
                        end
                    end else if (dev_hit) begin
                        dev_addr_d = pr_addr;
                        sel_d      = dev_idx;
                        if (WAIT_CYC == 0) begin
                            rdata_d = idx_word;
                            state_d = ST_RESP;
                        end else begin
                            cnt_d   = 4'(WAIT_CYC);
                            state_d = ST_WAIT;
                        end
                    end else begin
                        ready = 1'b1;
                        if (!pr_we && dm_hit) rd = dm_rdata;
`ifdef BRIDGE_ERR_EN
                        if (!pr_we && err_hit) rd = pr_addr[2] ? {31'b0, err_flag_q} : err_addr_q;
`endif
                        err_clr = err_hit && pr_we;
                        err_set = unmapped;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = '0;
                    rdata_d = sel_word;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                ready   = 1'b1;
                rd      = rdata_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Combinational completions are masked so nothing leaks out while reset is held.
    assign pr_ready   = reset_n & ready;
    assign pr_rd      = reset_n ? rd : '0;
    assign dev_we     = reset_n ? we_vec : '0;
    assign dev_wd     = reset_n ? wd_out : '0;
    assign dev_addr   = reset_n ? addr_out : '0;
    assign int_byteen = reset_n & pr_req & int_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rdata_q    <= '0;
            dev_addr_q <= '0;
            dev_wd_q   <= '0;
            sel_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            dev_addr_q <= dev_addr_d;
            dev_wd_q   <= dev_wd_d;
            sel_q      <= sel_d;
        end
    end

`ifdef BRIDGE_ERR_EN
    // A clearing write beats an error raised in the same cycle.
    always_comb begin
        err_flag_d = err_flag_q;
        err_addr_d = err_addr_q;
        if (err_set) begin
            err_flag_d = 1'b1;
            err_addr_d = pr_addr;
        end
        if (err_clr) err_flag_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_flag_q <= 1'b0;
            err_addr_q <= '0;
        end else begin
            err_flag_q <= err_flag_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err_flag = err_flag_q;
`else
    logic err_unused;
    assign err_unused = err_set | err_clr;
    assign err_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_multi_dev_bridge.sv
// Randomized bench for multi_dev_bridge against a transaction-level address-map model.
// Expectations follow BRIDGE_ERR_EN when it is defined for the build.
module tb_multi_dev_bridge;

    localparam int          N_DEV    = 2;
    localparam int          WAIT_CYC = 1;
    localparam logic [31:0] DEV_BASE = 32'h0000_7f00;

    localparam int R_DM   = 0;
    localparam int R_INT  = 1;
    localparam int R_ERR  = 2;
    localparam int R_UNM  = 3;
    localparam int R_DEV0 = 10;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                pr_req, pr_we;
    logic [3:0]          pr_byteen;
    logic [31:0]         pr_addr, pr_wd, pr_rd;
    logic                pr_ready;
    logic [31:0]         dev_addr, dev_wd;
    logic [N_DEV-1:0]    dev_we;
    logic [32*N_DEV-1:0] dev_rd;
    logic [31:0]         dm_rdata;
    logic                int_byteen, err_flag;
    logic [31:0]         dev_words [N_DEV];

    int          check_count = 0;
    int          pass_count  = 0;
    logic        model_err_flag = 1'b0;
    logic [31:0] model_err_addr = '0;

    always #5 clk = ~clk;

    assign dev_rd = {dev_words[1], dev_words[0]};

    multi_dev_bridge #(.N_DEV(N_DEV), .DEV_BASE(DEV_BASE), .WAIT_CYC(WAIT_CYC)) dut (
        .clk(clk), .reset_n(reset_n), .pr_req(pr_req), .pr_we(pr_we),
        .pr_byteen(pr_byteen), .pr_addr(pr_addr), .pr_wd(pr_wd), .pr_rd(pr_rd),
        .pr_ready(pr_ready), .dev_addr(dev_addr), .dev_wd(dev_wd), .dev_we(dev_we),
        .dev_rd(dev_rd), .dm_rdata(dm_rdata), .int_byteen(int_byteen), .err_flag(err_flag)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp) pass_count++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic int region(input logic [31:0] a);
        logic [31:0] base;
        if (a <= 32'h0000_2fff) return R_DM;
        if (a >= 32'h0000_7f20 && a <= 32'h0000_7f23) return R_INT;
`ifdef BRIDGE_ERR_EN
        if (a >= 32'h0000_7f30 && a <= 32'h0000_7f37) return R_ERR;
`endif
        for (int k = 0; k < N_DEV; k++) begin
            base = DEV_BASE + 32'(16 * k);
            if (a >= base && a <= base + 32'd11) return R_DEV0 + k;
        end
        return R_UNM;
    endfunction

    // One full CPU transaction: hold the request until pr_ready, then one idle cycle.
    task automatic applyStimulus(input logic we, input logic [3:0] be, input logic [31:0] addr,
                                 input logic [31:0] wd);
        int          r, k, c, exp_lat;
        logic [31:0] exp_rd, exp_we;
        logic        good_wr, dev_read, is_err, is_clr, done;
        r        = region(addr);
        exp_lat  = 0;
        exp_rd   = '0;
        exp_we   = '0;
        good_wr  = 1'b0;
        dev_read = 1'b0;
        is_err   = 1'b0;
        is_clr   = 1'b0;
        if (r >= R_DEV0) begin
            k = r - R_DEV0;
            if (we && be == 4'hF) begin
                exp_we  = 32'd1 << k;
                good_wr = 1'b1;
            end else if (we) begin
                is_err = 1'b1;
            end else begin
                dev_read = 1'b1;
                exp_lat  = 1 + WAIT_CYC;
                exp_rd   = dev_words[k];
            end
        end else if (r == R_DM) begin
            if (!we) exp_rd = dm_rdata;
        end else if (r == R_ERR) begin
            if (we) is_clr = 1'b1;
            else exp_rd = (addr >= 32'h0000_7f34) ? {31'b0, model_err_flag} : model_err_addr;
        end else if (r == R_UNM) begin
            is_err = 1'b1;
        end

        @(negedge clk);
        pr_req    = 1'b1;
        pr_we     = we;
        pr_byteen = be;
        pr_addr   = addr;
        pr_wd     = wd;
        done      = 1'b0;
        c         = 0;
        while (!done && c < 20) begin
            #1;
            if (c == 0) checkOutput("int_byteen", {31'b0, int_byteen}, {31'b0, r == R_INT});
            if (pr_ready) begin
                done = 1'b1;
                checkOutput("latency", 32'(c), 32'(exp_lat));
                checkOutput("pr_rd", pr_rd, exp_rd);
                checkOutput("dev_we", 32'(dev_we), exp_we);
                if (good_wr) checkOutput("dev_wd", dev_wd, wd);
                if (dev_read) checkOutput("dev_addr", dev_addr, addr);
            end else begin
                checkOutput("stall_rd", pr_rd, 32'd0);
                checkOutput("stall_we", 32'(dev_we), 32'd0);
            end
            @(negedge clk);
            c++;
        end
        if (!done) checkOutput("ready_timeout", 32'd0, 32'd1);

`ifdef BRIDGE_ERR_EN
        if (is_err) begin
            model_err_flag = 1'b1;
            model_err_addr = addr;
        end
        if (is_clr) model_err_flag = 1'b0;
`endif
        pr_req = 1'b0;
        #1;
        checkOutput("err_flag", {31'b0, err_flag}, {31'b0, model_err_flag});
        checkOutput("idle_ready", {31'b0, pr_ready}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] addr;
        logic [3:0]  be;
        int          k;

        reset_n      = 1'b0;
        pr_req       = 1'b1;
        pr_we        = 1'b0;
        pr_byteen    = 4'hF;
        pr_addr      = 32'h0000_7f21;
        pr_wd        = '0;
        dm_rdata     = 32'h1111_2222;
        dev_words[0] = '0;
        dev_words[1] = '0;
        #12;
        checkOutput("rst_int_byteen", {31'b0, int_byteen}, 32'd0);
        pr_addr = 32'h0000_1000;
        #1;
        checkOutput("rst_ready", {31'b0, pr_ready}, 32'd0);
        checkOutput("rst_rd", pr_rd, 32'd0);
        checkOutput("rst_err", {31'b0, err_flag}, 32'd0);
        checkOutput("rst_dev_addr", dev_addr, 32'd0);
        pr_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        dev_words[0] = 32'h0BAD_0000;
        dev_words[1] = 32'hCAFE_0001;
        applyStimulus(1'b0, 4'hF, 32'h0000_7f14, 32'd0);
        applyStimulus(1'b1, 4'hF, 32'h0000_7f08, 32'h1234_5678);
        dm_rdata = 32'hDEAD_BEEF;
        applyStimulus(1'b0, 4'hF, 32'h0000_1000, 32'd0);
        applyStimulus(1'b0, 4'hF, 32'h0000_5000, 32'd0);
        applyStimulus(1'b0, 4'hF, 32'h0000_7f30, 32'd0);
        applyStimulus(1'b0, 4'hF, 32'h0000_7f34, 32'd0);
        applyStimulus(1'b1, 4'hF, 32'h0000_7f30, 32'd0);
        applyStimulus(1'b1, 4'b0011, 32'h0000_7f00, 32'hAAAA_5555);
        applyStimulus(1'b0, 4'hF, 32'h0000_7f0c, 32'd0);
        applyStimulus(1'b0, 4'hF, 32'h0000_2fff, 32'd0);
        applyStimulus(1'b0, 4'hF, 32'h0000_3000, 32'd0);
        applyStimulus(1'b0, 4'hF, 32'h0000_7f1b, 32'd0);

        // Reset in the middle of a device read must swallow the response.
        @(negedge clk);
        pr_req    = 1'b1;
        pr_we     = 1'b0;
        pr_byteen = 4'hF;
        pr_addr   = 32'h0000_7f10;
        @(negedge clk);
        #1;
        checkOutput("wait_ready", {31'b0, pr_ready}, 32'd0);
        reset_n = 1'b0;
        pr_req  = 1'b0;
        model_err_flag = 1'b0;
        model_err_addr = '0;
        #1;
        checkOutput("abort_ready", {31'b0, pr_ready}, 32'd0);
        checkOutput("abort_dev_addr", dev_addr, 32'd0);
        repeat (2) begin
            @(negedge clk);
            #1;
            checkOutput("abort_hold_ready", {31'b0, pr_ready}, 32'd0);
        end
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            checkOutput("post_rst_ready", {31'b0, pr_ready}, 32'd0);
            checkOutput("post_rst_rd", pr_rd, 32'd0);
        end
        applyStimulus(1'b0, 4'hF, 32'h0000_0004, 32'd0);

        for (int n = 0; n < 150; n++) begin
            dm_rdata     = $urandom;
            dev_words[0] = $urandom;
            dev_words[1] = $urandom;
            k = int'($urandom_range(0, N_DEV - 1));
            case ($urandom_range(0, 5))
                0: addr = $urandom_range(0, 32'h2fff);
                1: addr = DEV_BASE + 32'(16 * k) + $urandom_range(0, 11);
                2: addr = 32'h0000_7f20 + $urandom_range(0, 3);
                3: addr = 32'h0000_7f30 + $urandom_range(0, 7);
                4: addr = DEV_BASE + 32'(16 * k) + 32'd12 + $urandom_range(0, 3);
                default: addr = $urandom;
            endcase
            be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            applyStimulus(1'($urandom), be, addr, $urandom);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/multi_dev_bridge.md
MULTI_DEV_BRIDGE -- requirements
Module: multi_dev_bridge

Interface
REQ-001 Parameter N_DEV, default 2, number of device windows (legal 1..4).
REQ-002 Parameter DEV_BASE, default 32'h0000_7f00, base address of device window 0; window k starts at DEV_BASE + 16*k, spans 12 bytes (offsets 0x0..0xb).
REQ-003 Parameter WAIT_CYC, default 1, wait states inserted on device reads (legal 0..15).
REQ-004 clk  input  1  single system clock, all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 pr_req  input  1  CPU access request, sampled in IDLE.
REQ-007 pr_we  input  1  1 = write, 0 = read.
REQ-008 pr_byteen  input  4  CPU byte enables.
REQ-009 pr_addr  input  32  CPU byte address.
REQ-010 pr_wd  input  32  CPU write data.
REQ-011 pr_rd  output  32  read data to CPU, valid while pr_ready=1.
REQ-012 pr_ready  output  1  access complete; CPU stalls while pr_req=1 and pr_ready=0.
REQ-013 dev_addr / dev_wd  output  32 / 32  latched address / write data to devices.
REQ-014 dev_we  output  N_DEV  one-hot write strobe, one cycle per write.
REQ-015 dev_rd  input  32*N_DEV  packed device read data, window k at bits [32k+31:32k].
REQ-016 dm_rdata  input  32  data-memory read data.
REQ-017 int_byteen  output  1  high while pr_req=1 and pr_addr in 32'h7f20..32'h7f23.
REQ-018 err_flag  output  1  sticky bus-error flag.

Function
REQ-019 Decode: DM hit = pr_addr 0x0000..0x2fff; device k hit = window k; INT hit per REQ-017; ERR-register hit per REQ-034; anything else unmapped.
REQ-020 FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-021 IDLE, pr_req=1, device read: latch pr_addr into dev_addr, load wait counter with WAIT_CYC, go WAIT (WAIT_CYC=0 goes straight to RESP).
REQ-022 WAIT decrements counter each cycle; at 0, capture selected dev_rd into rdata_q and go RESP.
REQ-023 RESP: pr_ready=1, pr_rd=rdata_q for exactly one cycle, then IDLE.
REQ-024 IDLE, device write with pr_byteen=4'b1111: dev_we[k]=1 for that one cycle, dev_wd=pr_wd, pr_ready=1 same cycle; no state change.
REQ-025 Device write with pr_byteen != 4'b1111: no dev_we, pr_ready=1, treated as bus error.
REQ-026 DM, INT and unmapped accesses complete combinationally in IDLE: pr_ready=1 same cycle; DM read returns dm_rdata, INT and unmapped reads return 0.
REQ-027 pr_req, pr_addr and pr_we ignored outside IDLE; in-flight transaction completes from latched values even if pr_req falls.
REQ-028 pr_ready=0 and pr_rd=0 in WAIT and whenever no access completes.
REQ-029 dev_we never asserted outside IDLE; at most one bit set.
REQ-030 Unmapped access, or REQ-025 access: err_flag set on next edge, err_addr latches pr_addr; later errors overwrite err_addr.

Reset
REQ-031 reset_n low forces immediately: state IDLE, counter 0, rdata_q 0, dev_addr 0, dev_wd 0, err_flag 0, err_addr 0.
REQ-032 Outputs under reset: pr_ready 0, pr_rd 0, dev_we 0, int_byteen 0.
REQ-033 Reset asserted in WAIT or RESP aborts the transaction with no pr_ready pulse; first post-reset cycle is IDLE.

Configuration
REQ-034 Macro BRIDGE_ERR_EN defined: err_flag/err_addr implemented; read 0x7f30 returns err_addr, read 0x7f34 returns {31'b0, err_flag}, any write to 0x7f30..0x7f37 clears err_flag (clear wins over a same-cycle set); single-cycle completion.
REQ-035 Macro not defined: err_flag tied 0, no error registers, 0x7f30..0x7f37 unmapped (reads 0); decode and completion otherwise identical.

Verification
REQ-036 WAIT_CYC=1: read 0x7f14 with dev_rd[63:32]=32'hCAFE0001 -> pr_ready low 2 cycles, high on 3rd with pr_rd=32'hCAFE0001.
REQ-037 Write 0x7f08, pr_wd=32'h12345678, byteen 4'hF -> dev_we=2'b01 one cycle, dev_wd=32'h12345678, pr_ready same cycle.
REQ-038 Read 0x0000_1000 with dm_rdata=32'hDEADBEEF -> pr_ready same cycle, pr_rd=32'hDEADBEEF, dev_we=0.
REQ-039 BRIDGE_ERR_EN: read 0x0000_5000 -> pr_rd=0, err_flag=1, read 0x7f30 returns 32'h00005000; write 0x7f30 -> err_flag=0.
REQ-040 Write 0x7f00 byteen 4'b0011 -> dev_we=0, err_flag=1 (BRIDGE_ERR_EN) or 0 (undefined).
REQ-041 Drop reset_n during WAIT of a 0x7f10 read -> pr_ready never pulses, state IDLE, pr_rd=0 after release.
